// File: rtl/multi_line_buffer_pkg.sv
// Shared definitions for the multi-row line buffer and the window stages
// that consume its taps: default geometry, width helpers and tap slicing.
package multi_line_buffer_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_LINE_WIDTH = 640;
   localparam int DEF_NUM_LINES  = 3;

   // Index width for a range of n entries; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // LSB position of tap k (k = 0 is the current row) in a packed tap bus.
   function automatic int tap_lsb(input int k, input int data_width);
      return k * data_width;
   endfunction

   // MSB position of tap k in a packed tap bus.
   function automatic int tap_msb(input int k, input int data_width);
      return (k + 1) * data_width - 1;
   endfunction

endpackage

// File: rtl/multi_line_buffer_line_ram.sv
// Single line store: one shared address, asynchronous read of the old
// contents and a write of the new value on the same edge, so a read and a
// write to the same column in one cycle always return the previous row.
module line_ram
   import multi_line_buffer_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int DEPTH      = DEF_LINE_WIDTH,
   localparam int ADDR_WIDTH = idx_width(DEPTH)
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   assign rd_data = mem_r[addr];

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/multi_line_buffer.sv
// Multi-row line buffer: turns a raster pixel stream into vertically aligned
// columns of NUM_LINES pixels (current row plus the rows above it), with
// frame restart, column tracking, end-of-line marking and priming status.
module multi_line_buffer
   import multi_line_buffer_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int LINE_WIDTH = DEF_LINE_WIDTH,
   parameter  int NUM_LINES  = DEF_NUM_LINES,
   localparam int COL_W      = idx_width(LINE_WIDTH),
   localparam int ROW_W      = idx_width(NUM_LINES)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            sof_i,
   input  logic                            valid_i,
   input  logic [DATA_WIDTH-1:0]           data_i,
   output logic                            valid_o,
   output logic [DATA_WIDTH*NUM_LINES-1:0] taps_o,
   output logic [COL_W-1:0]                col_o,
   output logic                            eol_o,
   output logic                            primed_o
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(NUM_LINES - 1);
   localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

   logic [COL_W-1:0] col_r;
   logic [COL_W-1:0] col_cur_s;
   logic [COL_W-1:0] col_nxt_s;
   logic [ROW_W-1:0] rows_r;
   logic [ROW_W-1:0] rows_cur_s;
   logic [ROW_W-1:0] rows_nxt_s;
   logic             line_end_s;
   logic             primed_cur_s;

   logic [DATA_WIDTH-1:0]           ram_rd_s [NUM_LINES-1];
   logic [DATA_WIDTH-1:0]           ram_wr_s [NUM_LINES-1];
   logic [DATA_WIDTH*NUM_LINES-1:0] taps_nxt_s;

   // Effective position of this beat: a start-of-frame beat is column 0 of
   // row 0 regardless of where the previous frame stopped.
   always_comb begin
      col_cur_s  = col_r;
      rows_cur_s = rows_r;
      if (sof_i) begin
         col_cur_s  = '0;
         rows_cur_s = '0;
      end else begin
         col_cur_s  = col_r;
         rows_cur_s = rows_r;
      end
   end

   // Next column/row-fill values; rows saturate once every tap holds real data.
   always_comb begin
      line_end_s   = (col_cur_s == COL_LAST);
      primed_cur_s = (rows_cur_s == ROW_FULL);
      col_nxt_s    = col_cur_s;
      rows_nxt_s   = rows_cur_s;
      if (line_end_s) begin
         col_nxt_s = '0;
      end else begin
         col_nxt_s = col_cur_s + COL_ONE;
      end
      if (line_end_s && !primed_cur_s) begin
         rows_nxt_s = rows_cur_s + ROW_ONE;
      end else begin
         rows_nxt_s = rows_cur_s;
      end
   end

   // The RAMs form a vertical shift chain: RAM0 takes the new pixel, each
   // deeper RAM takes the row its predecessor is giving up at this column.
   genvar k;
   generate
      for (k = 0; k < NUM_LINES - 1; k++) begin : g_line
         if (k == 0) begin : g_first
            assign ram_wr_s[k] = data_i;
         end else begin : g_chain
            assign ram_wr_s[k] = ram_rd_s[k-1];
         end

         line_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (LINE_WIDTH)
         ) u_line_ram (
            .clk     (clk),
            .addr    (col_cur_s),
            .wr_en   (valid_i),
            .wr_data (ram_wr_s[k]),
            .rd_data (ram_rd_s[k])
         );
      end
   endgenerate

   // Column assembled for this beat: current pixel in the LSBs, older rows above.
   always_comb begin
      taps_nxt_s = '0;
      taps_nxt_s[tap_msb(0, DATA_WIDTH):tap_lsb(0, DATA_WIDTH)] = data_i;
      for (int t = 1; t < NUM_LINES; t++) begin
         taps_nxt_s[tap_lsb(t, DATA_WIDTH) +: DATA_WIDTH] = ram_rd_s[t-1];
      end
   end

   // Counters, tap register and status flags advance only on accepted beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_r    <= '0;
         rows_r   <= '0;
         col_o    <= '0;
         eol_o    <= 1'b0;
         primed_o <= 1'b0;
         taps_o   <= '0;
         valid_o  <= 1'b0;
      end else if (valid_i) begin
         col_r    <= col_nxt_s;
         rows_r   <= rows_nxt_s;
         col_o    <= col_cur_s;
         eol_o    <= line_end_s;
         primed_o <= (rows_nxt_s == ROW_FULL);
         taps_o   <= taps_nxt_s;
         valid_o  <= primed_cur_s;
      end else begin
         valid_o  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_line_buffer.sv
// Directed bench for multi_line_buffer with a 4-pixel, 3-row geometry:
// reset, continuous and gapped streams, frame restart, asynchronous reset
// and a row-array reference model over three gapped frames.
module tb_multi_line_buffer;

   localparam int DW = 8;
   localparam int LW = 4;
   localparam int NL = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sof_i;
   logic          valid_i;
   logic [DW-1:0] data_i;
   logic          valid_o;
   logic [DW*NL-1:0] taps_o;
   logic [1:0]    col_o;
   logic          eol_o;
   logic          primed_o;

   int n_chk  = 0;
   int n_pass = 0;

   multi_line_buffer #(
      .DATA_WIDTH (DW),
      .LINE_WIDTH (LW),
      .NUM_LINES  (NL)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sof_i    (sof_i),
      .valid_i  (valid_i),
      .data_i   (data_i),
      .valid_o  (valid_o),
      .taps_o   (taps_o),
      .col_o    (col_o),
      .eol_o    (eol_o),
      .primed_o (primed_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 ns after the rising edge.
   task automatic beat(input logic s, input logic v, input logic [7:0] d);
      sof_i   = s;
      valid_i = v;
      data_i  = d;
      @(posedge clk);
      #1;
   endtask

   // Column expected for pixel p of the 1..16 stream: {p-8, p-4, p}.
   function automatic logic [31:0] exp_taps(input int p);
      return {8'h00, 8'(p - 8), 8'(p - 4), 8'(p)};
   endfunction

   task automatic run_stream(input bit gapped, input string tag);
      for (int p = 1; p <= 16; p++) begin
         if (gapped) begin
            // Idle beat with sof high: must be ignored and hold everything.
            beat(1'b1, 1'b0, 8'hEE);
            chk({tag, " idle valid"}, 32'(valid_o), 32'd0);
            if (p > 9) chk({tag, " idle taps hold"}, 32'(taps_o), exp_taps(p - 1));
         end
         beat(p == 1, 1'b1, 8'(p));
         chk({tag, " valid"}, 32'(valid_o), 32'(p >= 9));
         chk({tag, " col"}, 32'(col_o), 32'((p - 1) % 4));
         chk({tag, " eol"}, 32'(eol_o), 32'(((p - 1) % 4) == 3));
         if (p >= 9) chk({tag, " taps"}, 32'(taps_o), exp_taps(p));
         if (p == 7) chk({tag, " primed before"}, 32'(primed_o), 32'd0);
         if (p == 8) chk({tag, " primed after"}, 32'(primed_o), 32'd1);
      end
   endtask

   logic [7:0] fp [5][4];

   initial begin
      rst_n   = 1'b0;
      sof_i   = 1'b0;
      valid_i = 1'b0;
      data_i  = 8'h00;

      // Reset held with random inputs.
      for (int i = 0; i < 4; i++) begin
         beat(1'($urandom), 1'($urandom), 8'($urandom));
      end
      chk("rst valid_o", 32'(valid_o), 32'd0);
      chk("rst taps_o", 32'(taps_o), 32'd0);
      chk("rst col_o", 32'(col_o), 32'd0);
      chk("rst eol_o", 32'(eol_o), 32'd0);
      chk("rst primed_o", 32'(primed_o), 32'd0);
      rst_n = 1'b1;

      // Explicit values from the pixel 1..16 stream.
      run_stream(1'b0, "cont");
      chk("cont pix16 taps", 32'(taps_o), 32'h00080C10);
      run_stream(1'b1, "gap");
      chk("gap pix16 taps", 32'(taps_o), 32'h00080C10);

      // Mid-frame restart after pixel 10.
      for (int p = 1; p <= 10; p++) beat(p == 1, 1'b1, 8'(p));
      chk("pre-restart primed", 32'(primed_o), 32'd1);
      beat(1'b1, 1'b1, 8'h20);
      chk("restart primed", 32'(primed_o), 32'd0);
      chk("restart valid", 32'(valid_o), 32'd0);
      chk("restart col", 32'(col_o), 32'd0);
      for (int i = 1; i < 8; i++) begin
         beat(1'b0, 1'b1, 8'(8'h20 + i));
         chk("restart fill valid", 32'(valid_o), 32'd0);
      end
      beat(1'b0, 1'b1, 8'h28);
      chk("restart 9th valid", 32'(valid_o), 32'd1);
      chk("restart 9th taps", 32'(taps_o), 32'h00202428);
      chk("restart 9th col", 32'(col_o), 32'd0);

      // Asynchronous reset between edges, mid-row.
      for (int p = 1; p <= 6; p++) beat(p == 1, 1'b1, 8'(p));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async valid_o", 32'(valid_o), 32'd0);
      chk("async taps_o", 32'(taps_o), 32'd0);
      chk("async col_o", 32'(col_o), 32'd0);
      chk("async eol_o", 32'(eol_o), 32'd0);
      chk("async primed_o", 32'(primed_o), 32'd0);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         beat(1'b0, 1'b1, 8'(8'h41 + i));
         chk("post-rst col", 32'(col_o), 32'(i % 4));
         chk("post-rst valid", 32'(valid_o), 32'(i >= 8));
         if (i == 8) chk("post-rst taps", 32'(taps_o), 32'h00414549);
      end

      // Three gapped frames of random pixels against a row-array model.
      for (int f = 0; f < 3; f++) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
               automatic int n_idle = $urandom_range(0, 2);
               automatic logic [7:0] d = 8'($urandom);
               for (int g = 0; g < n_idle; g++) begin
                  beat(1'b0, 1'b0, 8'($urandom));
                  chk("sb idle valid", 32'(valid_o), 32'd0);
               end
               fp[r][c] = d;
               beat((r == 0) && (c == 0), 1'b1, d);
               chk("sb valid", 32'(valid_o), 32'(r >= 2));
               chk("sb col", 32'(col_o), 32'(c));
               chk("sb eol", 32'(eol_o), 32'(c == 3));
               if (r >= 2) chk("sb taps", 32'(taps_o), {8'h00, fp[r-2][c], fp[r-1][c], d});
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
